// File: rtl/video_frame_scheduler.sv
// Frame-aligned start/stop gate between CMOS capture and the RAW8 processor.
// Define FRAME_CHECK_EN to add pixel/line counting and the sticky geom_err flag.
module video_frame_scheduler #(
   parameter logic [9:0] IMG_HDISP        = 10'd640,
   parameter logic [9:0] IMG_VDISP        = 10'd480,
   parameter logic       CMOS_VSYNC_VALID = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic        cmd_start,
   output logic        cmd_ready,
   input  logic        per_frame_vsync,
   input  logic        per_frame_href,
   input  logic [7:0]  per_img_RAW,
   output logic        post_frame_vsync,
   output logic        post_frame_href,
   output logic [7:0]  post_img_RAW,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_cnt
`ifdef FRAME_CHECK_EN
   ,
   output logic        geom_err
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      ACTIVE,
      DRAIN
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   vsync_q;
   logic   fs;
   logic   start_acc;
   logic   stop_acc;
   logic   gate_nxt;
   logic   done_nxt;

   assign fs = (per_frame_vsync == CMOS_VSYNC_VALID) &&
               (vsync_q != CMOS_VSYNC_VALID);
   assign start_acc = cmd_valid & cmd_ready & cmd_start;
   assign stop_acc  = cmd_valid & cmd_ready & ~cmd_start;

   // A stop that lands on the arming fs cancels before the gate opens.
   always_comb begin
      state_nxt = state;
      gate_nxt  = 1'b0;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_acc) state_nxt = ARM;
         end
         ARM: begin
            if (stop_acc) begin
               state_nxt = IDLE;
            end else if (fs) begin
               state_nxt = ACTIVE;
               gate_nxt  = 1'b1;
            end
         end
         ACTIVE: begin
            gate_nxt = 1'b1;
            done_nxt = fs;
            if (stop_acc) state_nxt = DRAIN;
         end
         DRAIN: begin
            gate_nxt = ~fs;
            done_nxt = fs;
            if (fs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cmd_ready        <= 1'b1;
         busy             <= 1'b0;
         vsync_q          <= ~CMOS_VSYNC_VALID;
         post_frame_vsync <= ~CMOS_VSYNC_VALID;
         post_frame_href  <= 1'b0;
         post_img_RAW     <= 8'd0;
         frame_done       <= 1'b0;
         frame_cnt        <= 16'd0;
      end else begin
         state     <= state_nxt;
         cmd_ready <= (state_nxt != DRAIN);
         busy      <= (state_nxt != IDLE);
         vsync_q   <= per_frame_vsync;
         if (gate_nxt) begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_img_RAW     <= per_img_RAW;
         end else begin
            post_frame_vsync <= ~CMOS_VSYNC_VALID;
            post_frame_href  <= 1'b0;
            post_img_RAW     <= 8'd0;
         end
         frame_done <= done_nxt;
         if (done_nxt) frame_cnt <= frame_cnt + 16'd1;
      end
   end

`ifdef FRAME_CHECK_EN
   logic       href_q;
   logic       href_fall;
   logic [9:0] pix_cnt;
   logic [9:0] line_cnt;
   logic       pix_bad;
   logic       line_bad;

   assign href_fall = href_q & ~per_frame_href;
   assign pix_bad   = gate_nxt & href_fall & (pix_cnt != IMG_HDISP);
   assign line_bad  = done_nxt & (line_cnt != IMG_VDISP);

   always_ff @(posedge clk) begin
      if (rst) begin
         href_q   <= 1'b0;
         pix_cnt  <= 10'd0;
         line_cnt <= 10'd0;
         geom_err <= 1'b0;
      end else begin
         href_q <= per_frame_href;
         if (gate_nxt) begin
            if (per_frame_href) begin
               if (pix_cnt != 10'h3FF) pix_cnt <= pix_cnt + 10'd1;
            end else if (href_fall) begin
               pix_cnt <= 10'd0;
            end
            if (fs) begin
               line_cnt <= 10'd0;
            end else if (href_fall && line_cnt != 10'h3FF) begin
               line_cnt <= line_cnt + 10'd1;
            end
         end
         if (start_acc) begin
            geom_err <= 1'b0;
         end else if (pix_bad || line_bad) begin
            geom_err <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_video_frame_scheduler.sv
// Randomized frame-level bench for video_frame_scheduler.
// Expected pixel stream and frame counts come from a per-frame command model.
module tb_video_frame_scheduler;

   localparam int HD = 16;
   localparam int VD = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_start;
   logic        cmd_ready;
   logic        per_frame_vsync;
   logic        per_frame_href;
   logic [7:0]  per_img_RAW;
   logic        post_frame_vsync;
   logic        post_frame_href;
   logic [7:0]  post_img_RAW;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;
`ifdef FRAME_CHECK_EN
   logic        geom_err;
`endif

   always #5 clk = ~clk;

   video_frame_scheduler #(
      .IMG_HDISP(10'(HD)),
      .IMG_VDISP(10'(VD)),
      .CMOS_VSYNC_VALID(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .cmd_valid(cmd_valid),
      .cmd_start(cmd_start),
      .cmd_ready(cmd_ready),
      .per_frame_vsync(per_frame_vsync),
      .per_frame_href(per_frame_href),
      .per_img_RAW(per_img_RAW),
      .post_frame_vsync(post_frame_vsync),
      .post_frame_href(post_frame_href),
      .post_img_RAW(post_img_RAW),
      .busy(busy),
      .frame_done(frame_done),
      .frame_cnt(frame_cnt)
`ifdef FRAME_CHECK_EN
      ,
      .geom_err(geom_err)
`endif
   );

   typedef enum {M_IDLE, M_ARM, M_ACT, M_DRN} mode_t;

   mode_t       m_mode;
   logic [15:0] m_cnt;
   int          m_done;
   int          mon_done;
   int          lat_bad;
   int          n_chk;
   int          n_fail;
   int          cyc_idx;
   int          g_cmd_at;
   bit          g_cmd_st;
   logic [7:0]  exp_q[$];
   logic [7:0]  mon_q[$];

   always @(negedge clk) begin
      if (post_frame_href === 1'b1) mon_q.push_back(post_img_RAW);
      if (frame_done === 1'b1) mon_done++;
   end

   function automatic bit q_match();
      if (mon_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[i]) if (mon_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic cyc();
      cmd_valid = (cyc_idx == g_cmd_at);
      cmd_start = g_cmd_st;
      @(posedge clk);
      #1;
      cyc_idx++;
   endtask

   // One frame: 2 vsync cycles, 2 gap, VD lines of HD bytes + 3 gap, 2 tail.
   task automatic send_frame(input int short_ln, input int cmd_at,
                             input bit cmd_st);
      bit         pass;
      int         len;
      logic [7:0] d;
      cyc_idx  = 0;
      g_cmd_at = cmd_at;
      g_cmd_st = cmd_st;
      if (cmd_at == 0 && !cmd_st && m_mode == M_ARM) m_mode = M_IDLE;
      case (m_mode)
         M_ARM: m_mode = M_ACT;
         M_ACT: begin m_done++; m_cnt++; end
         M_DRN: begin m_done++; m_cnt++; m_mode = M_IDLE; end
         default: ;
      endcase
      pass = (m_mode == M_ACT);
      if (cmd_at >= 0) begin
         if (cmd_st && m_mode == M_IDLE) m_mode = M_ARM;
         else if (!cmd_st && m_mode == M_ARM) m_mode = M_IDLE;
         else if (!cmd_st && m_mode == M_ACT) m_mode = M_DRN;
      end
      per_frame_href  = 1'b0;
      per_img_RAW     = 8'd0;
      per_frame_vsync = 1'b1;
      repeat (2) cyc();
      per_frame_vsync = 1'b0;
      repeat (2) cyc();
      for (int l = 0; l < VD; l++) begin
         len = (l == short_ln) ? HD - 1 : HD;
         for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            per_frame_href = 1'b1;
            per_img_RAW    = d;
            if (pass) exp_q.push_back(d);
            cyc();
            if (pass ? (post_frame_href !== 1'b1 || post_img_RAW !== d)
                     : (post_frame_href !== 1'b0)) lat_bad++;
         end
         per_frame_href = 1'b0;
         per_img_RAW    = 8'd0;
         repeat (3) cyc();
      end
      repeat (2) cyc();
      g_cmd_at = -1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cyc();
      n_chk++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctl ready=%b busy=%b exp 1/0", cmd_ready, busy);
      end
      n_chk++;
      if (post_frame_vsync !== 1'b0 || post_frame_href !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sync vs=%b hr=%b exp 0/0",
                  post_frame_vsync, post_frame_href);
      end
      n_chk++;
      if (post_img_RAW !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_raw got=%h exp=00", post_img_RAW);
      end
      n_chk++;
      if (frame_done !== 1'b0 || frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_cnt done=%b cnt=%h exp 0/0000",
                  frame_done, frame_cnt);
      end
`ifdef FRAME_CHECK_EN
      n_chk++;
      if (geom_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_geom got=%b exp=0", geom_err);
      end
`endif
      rst = 1'b0;
      repeat (2) cyc();
   endtask

   task automatic test_start();
      send_frame(-1, 10, 1'b1);
      n_chk++;
      if (busy !== 1'b1 || mon_q.size() != 0) begin
         n_fail++;
         $display("FAIL start_arm busy=%b out=%0d exp 1/0", busy, mon_q.size());
      end
      send_frame(-1, -1, 1'b0);
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (frame_cnt !== m_cnt || m_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL start_cnt got=%h exp=%h", frame_cnt, m_cnt);
      end
      n_chk++;
      if (mon_done !== m_done) begin
         n_fail++;
         $display("FAIL start_done got=%0d exp=%0d", mon_done, m_done);
      end
      n_chk++;
      if (!q_match()) begin
         n_fail++;
         $display("FAIL start_data got=%0d bytes exp=%0d bytes",
                  mon_q.size(), exp_q.size());
      end
      n_chk++;
      if (lat_bad !== 0) begin
         n_fail++;
         $display("FAIL start_latency bad=%0d exp=0", lat_bad);
      end
   endtask

   task automatic test_stop();
      send_frame(-1, 4 + (HD + 3) + 5, 1'b0);
      n_chk++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL stop_drain ready=%b busy=%b exp 0/1", cmd_ready, busy);
      end
      send_frame(-1, -1, 1'b0);
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle ready=%b busy=%b exp 1/0", cmd_ready, busy);
      end
      n_chk++;
      if (frame_cnt !== m_cnt || mon_done !== m_done) begin
         n_fail++;
         $display("FAIL stop_cnt got=%h/%0d exp=%h/%0d",
                  frame_cnt, mon_done, m_cnt, m_done);
      end
      n_chk++;
      if (!q_match() || lat_bad !== 0) begin
         n_fail++;
         $display("FAIL stop_data got=%0d bytes exp=%0d lat=%0d",
                  mon_q.size(), exp_q.size(), lat_bad);
      end
   endtask

   task automatic test_arm_stop();
      logic [15:0] c0;
      c0 = frame_cnt;
      send_frame(-1, 30, 1'b1);
      send_frame(-1, 0, 1'b0);
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (busy !== 1'b0 || frame_cnt !== c0 || frame_cnt !== m_cnt) begin
         n_fail++;
         $display("FAIL armstop_state busy=%b cnt=%h exp 0/%h",
                  busy, frame_cnt, m_cnt);
      end
      n_chk++;
      if (!q_match() || lat_bad !== 0 || mon_done !== m_done) begin
         n_fail++;
         $display("FAIL armstop_quiet out=%0d exp=%0d done=%0d exp=%0d",
                  mon_q.size(), exp_q.size(), mon_done, m_done);
      end
   endtask

`ifdef FRAME_CHECK_EN
   task automatic test_geom();
      send_frame(-1, 10, 1'b1);
      send_frame(1, -1, 1'b0);
      n_chk++;
      if (geom_err !== 1'b1) begin
         n_fail++;
         $display("FAIL geom_set got=%b exp=1", geom_err);
      end
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (geom_err !== 1'b1) begin
         n_fail++;
         $display("FAIL geom_sticky got=%b exp=1", geom_err);
      end
      send_frame(-1, 10, 1'b1);
      n_chk++;
      if (geom_err !== 1'b0) begin
         n_fail++;
         $display("FAIL geom_clear got=%b exp=0", geom_err);
      end
   endtask
`endif

   task automatic test_wrap();
      int md0;
      if (m_mode == M_IDLE) begin
         send_frame(-1, 10, 1'b1);
         send_frame(-1, -1, 1'b0);
      end
      force dut.frame_cnt = 16'hFFFF;
      #1;
      release dut.frame_cnt;
      m_cnt = 16'hFFFF;
      md0   = mon_done;
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (frame_cnt !== 16'h0000) begin
         n_fail++;
         $display("FAIL wrap_cnt got=%h exp=0000", frame_cnt);
      end
      n_chk++;
      if (mon_done - md0 !== 1) begin
         n_fail++;
         $display("FAIL wrap_done got=%0d pulses exp=1", mon_done - md0);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      g_cmd_at = -1;
      cyc_idx  = 0;
      m_done++;
      m_cnt++;
      per_frame_vsync = 1'b1;
      repeat (2) cyc();
      per_frame_vsync = 1'b0;
      repeat (2) cyc();
      for (int b = 0; b < 5; b++) begin
         d = 8'($urandom);
         per_frame_href = 1'b1;
         per_img_RAW    = d;
         exp_q.push_back(d);
         cyc();
      end
      rst         = 1'b1;
      per_img_RAW = 8'hA5;
      cyc();
      n_chk++;
      if (post_frame_href !== 1'b0 || post_img_RAW !== 8'd0 ||
          post_frame_vsync !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_out hr=%b raw=%h vs=%b exp 0/00/0",
                  post_frame_href, post_img_RAW, post_frame_vsync);
      end
      n_chk++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_state busy=%b ready=%b cnt=%h exp 0/1/0000",
                  busy, cmd_ready, frame_cnt);
      end
      m_mode = M_IDLE;
      m_cnt  = 16'd0;
      rst    = 1'b0;
      for (int b = 0; b < HD - 6; b++) begin
         per_img_RAW = 8'($urandom);
         cyc();
      end
      per_frame_href = 1'b0;
      per_img_RAW    = 8'd0;
      repeat (40) cyc();
      send_frame(-1, 10, 1'b1);
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (!q_match() || frame_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmid_restart out=%0d exp=%0d cnt=%h exp=0000",
                  mon_q.size(), exp_q.size(), frame_cnt);
      end
      send_frame(-1, -1, 1'b0);
      n_chk++;
      if (frame_cnt !== m_cnt || mon_done !== m_done || lat_bad !== 0) begin
         n_fail++;
         $display("FAIL rstmid_cnt got=%h/%0d exp=%h/%0d lat=%0d",
                  frame_cnt, mon_done, m_cnt, m_done, lat_bad);
      end
   endtask

   initial begin
      rst             = 1'b1;
      cmd_valid       = 1'b0;
      cmd_start       = 1'b0;
      per_frame_vsync = 1'b0;
      per_frame_href  = 1'b0;
      per_img_RAW     = 8'd0;
      m_mode          = M_IDLE;
      m_cnt           = 16'd0;
      m_done          = 0;
      mon_done        = 0;
      lat_bad         = 0;
      n_chk           = 0;
      n_fail          = 0;
      cyc_idx         = 0;
      g_cmd_at        = -1;
      g_cmd_st        = 1'b0;
      test_reset();
      test_start();
      test_stop();
      test_arm_stop();
`ifdef FRAME_CHECK_EN
      test_geom();
`endif
      test_wrap();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
